// File: rtl/period_peak_tracker_if.sv
// period_peak_tracker_if
//   Groups the sample stream, the measurement handshake and the result bus
//   of period_peak_tracker into one bundle.
//
//   Stream   : sample_en (valid strobe), adc_data (unsigned sample),
//              signal_in (synchronised comparator square wave)
//   Handshake: start (one-cycle request), busy, done (one-cycle pulse),
//              timeout (1 = last measurement aborted)
//   Results  : vmax, vmin, vpp, sample_cnt (stable between done pulses)
//
//   master : the side that feeds samples and requests measurements
//   slave  : the tracker itself
interface period_peak_tracker_if #(
  parameter int DW = 12
);
  logic          sample_en;
  logic [DW-1:0] adc_data;
  logic          signal_in;
  logic          start;
  logic          busy;
  logic          done;
  logic          timeout;
  logic [DW-1:0] vmax;
  logic [DW-1:0] vmin;
  logic [DW-1:0] vpp;
  logic [15:0]   sample_cnt;

  modport master (
    output sample_en, adc_data, signal_in, start,
    input  busy, done, timeout, vmax, vmin, vpp, sample_cnt
  );

  modport slave (
    input  sample_en, adc_data, signal_in, start,
    output busy, done, timeout, vmax, vmin, vpp, sample_cnt
  );
endinterface

// File: rtl/period_peak_tracker.sv
// period_peak_tracker
//   Measures max, min, peak-to-peak and sample count of the ADC stream over
//   NUM_PERIODS whole periods of signal_in (rising edge to rising edge).
//   A measurement that does not complete within TIMEOUT_CYC cycles of the
//   start request is aborted; an abort reports timeout=1 and leaves the
//   previous results untouched.
//
//   clk  : sole clock
//   rst  : synchronous, active-high reset
//   bus  : period_peak_tracker_if.slave (stream in, handshake, results out)
module period_peak_tracker #(
  parameter int NUM_PERIODS = 4,
  parameter int TIMEOUT_CYC = 50_000_000,
  parameter int DW          = 12
) (
  input logic                  clk,
  input logic                  rst,
  period_peak_tracker_if.slave bus
);

  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  // Abort fires when the incremented count would reach TIMEOUT_CYC-1, so done
  // lands exactly TIMEOUT_CYC cycles after the start request.
  localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT_CYC - 2);
  localparam logic [7:0]    PCNT_LAST = 8'(NUM_PERIODS - 1);
  localparam logic [DW-1:0] DATA_MAX  = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_EDGE,
    S_MEASURE,
    S_DONE,
    S_ABORT
  } state_t;

  state_t        state_q, state_d;
  logic          sig_q, sig_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [7:0]    pcnt_q, pcnt_d;
  logic [DW-1:0] max_q, max_d;
  logic [DW-1:0] min_q, min_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          timeout_q, timeout_d;
  logic [DW-1:0] vmax_q, vmax_d;
  logic [DW-1:0] vmin_q, vmin_d;
  logic [DW-1:0] vpp_q, vpp_d;
  logic [15:0]   scnt_q, scnt_d;

  logic rise;
  logic final_rise;
  logic expired;

  always_comb begin
    state_d    = state_q;
    sig_d      = bus.signal_in;
    tcnt_d     = tcnt_q;
    pcnt_d     = pcnt_q;
    max_d      = max_q;
    min_d      = min_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    timeout_d  = timeout_q;
    vmax_d     = vmax_q;
    vmin_d     = vmin_q;
    vpp_d      = vpp_q;
    scnt_d     = scnt_q;

    rise       = bus.signal_in & ~sig_q;
    final_rise = rise && (pcnt_q == PCNT_LAST);
    expired    = (tcnt_q == TCNT_LAST);

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_WAIT_EDGE;
          tcnt_d  = '0;
          busy_d  = 1'b1;
        end
      end

      S_WAIT_EDGE: begin
        tcnt_d = tcnt_q + TW'(1);
        if (rise) begin
          state_d = S_MEASURE;
          pcnt_d  = '0;
          // A sample on the opening edge is the first sample of the window.
          if (bus.sample_en) begin
            max_d = bus.adc_data;
            min_d = bus.adc_data;
            cnt_d = 16'd1;
          end else begin
            max_d = '0;
            min_d = DATA_MAX;
            cnt_d = '0;
          end
        end
        if (expired) begin
          state_d   = S_ABORT;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          timeout_d = 1'b1;
        end
      end

      S_MEASURE: begin
        tcnt_d = tcnt_q + TW'(1);
        if (rise) begin
          pcnt_d = pcnt_q + 8'd1;
        end
        // The sample on the closing edge belongs to the next period.
        if (bus.sample_en && !final_rise) begin
          if (bus.adc_data > max_q) max_d = bus.adc_data;
          if (bus.adc_data < min_q) min_d = bus.adc_data;
          if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
        end
        // Completion takes priority over a timeout expiring on the same cycle.
        if (final_rise) begin
          state_d   = S_DONE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          timeout_d = 1'b0;
          vmax_d    = max_q;
          vmin_d    = min_q;
          vpp_d     = (max_q >= min_q) ? (max_q - min_q) : '0;
          scnt_d    = cnt_q;
        end else if (expired) begin
          state_d   = S_ABORT;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          timeout_d = 1'b1;
        end
      end

      // Results and done were registered on entry; these states only hold
      // for the single cycle that done is high.
      S_DONE:  state_d = S_IDLE;
      S_ABORT: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // sig_q resets high so a signal_in already high out of reset is not an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      sig_q     <= 1'b1;
      tcnt_q    <= '0;
      pcnt_q    <= '0;
      max_q     <= '0;
      min_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      vmax_q    <= '0;
      vmin_q    <= '0;
      vpp_q     <= '0;
      scnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      sig_q     <= sig_d;
      tcnt_q    <= tcnt_d;
      pcnt_q    <= pcnt_d;
      max_q     <= max_d;
      min_q     <= min_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      vmax_q    <= vmax_d;
      vmin_q    <= vmin_d;
      vpp_q     <= vpp_d;
      scnt_q    <= scnt_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.timeout    = timeout_q;
  assign bus.vmax       = vmax_q;
  assign bus.vmin       = vmin_q;
  assign bus.vpp        = vpp_q;
  assign bus.sample_cnt = scnt_q;

endmodule

// File: tb/tb_period_peak_tracker.sv
// tb_period_peak_tracker
//   Directed bench for period_peak_tracker. Two instances share the same
//   stimulus: dut_a measures 2 periods, dut_b measures 1 period; both abort
//   after 100 cycles. Inputs change 1 time unit after a rising edge and
//   outputs are read at the same point, away from the active edge.
module tb_period_peak_tracker;

  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          sample_en;
  logic          signal_in;
  logic [DW-1:0] adc_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  period_peak_tracker_if #(.DW(DW)) bus_a ();
  period_peak_tracker_if #(.DW(DW)) bus_b ();

  assign bus_a.start     = start;
  assign bus_a.sample_en = sample_en;
  assign bus_a.signal_in = signal_in;
  assign bus_a.adc_data  = adc_data;
  assign bus_b.start     = start;
  assign bus_b.sample_en = sample_en;
  assign bus_b.signal_in = signal_in;
  assign bus_b.adc_data  = adc_data;

  period_peak_tracker #(.NUM_PERIODS(2), .TIMEOUT_CYC(100), .DW(DW)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  period_peak_tracker #(.NUM_PERIODS(1), .TIMEOUT_CYC(100), .DW(DW)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  // Square wave low for 'lead' cycles, then high for the first half of each period.
  function automatic logic sig_at(input int t, input int lead, input int period);
    if (t < lead) return 1'b0;
    return ((t - lead) % period) < (period / 2);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic sig_level);
    rst       = 1'b1;
    start     = 1'b0;
    sample_en = 1'b0;
    adc_data  = '0;
    signal_in = sig_level;
    step();
    step();
    rst = 1'b0;
  endtask

  // Pulses start for one cycle; the start is sampled on the returned-from edge.
  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(1'b1);
    n_checks++; if (bus_a.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 0", bus_a.busy); end
    n_checks++; if (bus_a.done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done: got %b expected 0", bus_a.done); end
    n_checks++; if (bus_a.timeout !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_timeout: got %b expected 0", bus_a.timeout); end
    n_checks++; if (bus_a.vmax !== 12'd0) begin n_fail++; $display("[TB] FAIL reset_vmax: got %0d expected 0", bus_a.vmax); end
    n_checks++; if (bus_a.vmin !== 12'd0) begin n_fail++; $display("[TB] FAIL reset_vmin: got %0d expected 0", bus_a.vmin); end
    n_checks++; if (bus_a.vpp !== 12'd0) begin n_fail++; $display("[TB] FAIL reset_vpp: got %0d expected 0", bus_a.vpp); end
    n_checks++; if (bus_a.sample_cnt !== 16'd0) begin n_fail++; $display("[TB] FAIL reset_cnt: got %0d expected 0", bus_a.sample_cnt); end
  endtask

  // signal_in stays high from reset, so no edge is ever seen and the
  // measurement must abort with done high 100 cycles after the start cycle.
  task automatic test_timeout_no_edge();
    int done_at = -1;
    pulse_start();
    n_checks++; if (bus_a.busy !== 1'b1) begin n_fail++; $display("[TB] FAIL to_busy_after_start: got %b expected 1", bus_a.busy); end
    for (int k = 1; k <= 200; k++) begin
      step();
      if (bus_a.done === 1'b1) begin
        done_at = k;
        break;
      end
    end
    n_checks++; if (done_at != 99) begin n_fail++; $display("[TB] FAIL to_done_cycle: got %0d expected 99", done_at); end
    n_checks++; if (bus_a.timeout !== 1'b1) begin n_fail++; $display("[TB] FAIL to_timeout: got %b expected 1", bus_a.timeout); end
    n_checks++; if (bus_a.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL to_busy_at_done: got %b expected 0", bus_a.busy); end
    n_checks++; if (bus_a.vmax !== 12'd0) begin n_fail++; $display("[TB] FAIL to_vmax: got %0d expected 0", bus_a.vmax); end
    n_checks++; if (bus_a.vmin !== 12'd0) begin n_fail++; $display("[TB] FAIL to_vmin: got %0d expected 0", bus_a.vmin); end
    n_checks++; if (bus_a.vpp !== 12'd0) begin n_fail++; $display("[TB] FAIL to_vpp: got %0d expected 0", bus_a.vpp); end
    n_checks++; if (bus_a.sample_cnt !== 16'd0) begin n_fail++; $display("[TB] FAIL to_cnt: got %0d expected 0", bus_a.sample_cnt); end
    step();
    n_checks++; if (bus_a.done !== 1'b0) begin n_fail++; $display("[TB] FAIL to_done_one_cycle: got %b expected 0", bus_a.done); end
  endtask

  // Period 40, sample every 4 cycles from the first rise, ramp 100..1000
  // wrapping. A stray 4000 sample before the first rise must be ignored.
  task automatic test_ramp();
    int done_at = -1;
    do_reset(1'b0);
    pulse_start();
    for (int t = 0; t < 150; t++) begin
      signal_in = sig_at(t, 5, 40);
      sample_en = (t == 1) || ((t >= 5) && ((t - 5) % 4 == 0));
      adc_data  = (t == 1) ? 12'd4000 : 12'(100 + 100 * (((t - 5) / 4) % 10));
      step();
      if (bus_a.done === 1'b1) begin
        done_at = t;
        break;
      end
    end
    sample_en = 1'b0;
    n_checks++; if (done_at != 85) begin n_fail++; $display("[TB] FAIL ramp_done_cycle: got %0d expected 85", done_at); end
    n_checks++; if (bus_a.timeout !== 1'b0) begin n_fail++; $display("[TB] FAIL ramp_timeout: got %b expected 0", bus_a.timeout); end
    n_checks++; if (bus_a.sample_cnt !== 16'd20) begin n_fail++; $display("[TB] FAIL ramp_cnt: got %0d expected 20", bus_a.sample_cnt); end
    n_checks++; if (bus_a.vmax !== 12'd1000) begin n_fail++; $display("[TB] FAIL ramp_vmax: got %0d expected 1000", bus_a.vmax); end
    n_checks++; if (bus_a.vmin !== 12'd100) begin n_fail++; $display("[TB] FAIL ramp_vmin: got %0d expected 100", bus_a.vmin); end
    n_checks++; if (bus_a.vpp !== 12'd900) begin n_fail++; $display("[TB] FAIL ramp_vpp: got %0d expected 900", bus_a.vpp); end
    step();
    n_checks++; if (bus_a.done !== 1'b0) begin n_fail++; $display("[TB] FAIL ramp_done_one_cycle: got %b expected 0", bus_a.done); end
    n_checks++; if (bus_a.vmax !== 12'd1000) begin n_fail++; $display("[TB] FAIL ramp_vmax_stable: got %0d expected 1000", bus_a.vmax); end
  endtask

  // Rises at t=3,23,43 (period 20). Samples on the opening rise (4095) and
  // on an intermediate rise (260) count; the sample on the closing rise is
  // excluded. dut_b (1 period) closes at t=23, so its 260 is excluded.
  task automatic test_edge_samples();
    int          done_a = -1;
    int          done_b = -1;
    logic [11:0] b_vmax = '0;
    logic [11:0] b_vmin = '0;
    logic [15:0] b_cnt  = '0;
    do_reset(1'b0);
    pulse_start();
    for (int t = 0; t < 150; t++) begin
      signal_in = sig_at(t, 3, 20);
      sample_en = 1'b1;
      case (t)
        3:       adc_data = 12'd4095;
        8:       adc_data = 12'd300;
        18:      adc_data = 12'd700;
        23:      adc_data = 12'd260;
        28:      adc_data = 12'd250;
        38:      adc_data = 12'd900;
        43:      adc_data = 12'd0;
        default: begin sample_en = 1'b0; adc_data = 12'd0; end
      endcase
      step();
      if (bus_b.done === 1'b1 && done_b < 0) begin
        done_b = t;
        b_vmax = bus_b.vmax;
        b_vmin = bus_b.vmin;
        b_cnt  = bus_b.sample_cnt;
      end
      if (bus_a.done === 1'b1) begin
        done_a = t;
        break;
      end
    end
    sample_en = 1'b0;
    n_checks++; if (done_a != 43) begin n_fail++; $display("[TB] FAIL edge_done_cycle: got %0d expected 43", done_a); end
    n_checks++; if (bus_a.vmax !== 12'd4095) begin n_fail++; $display("[TB] FAIL edge_vmax: got %0d expected 4095", bus_a.vmax); end
    n_checks++; if (bus_a.vmin !== 12'd250) begin n_fail++; $display("[TB] FAIL edge_vmin: got %0d expected 250", bus_a.vmin); end
    n_checks++; if (bus_a.vpp !== 12'd3845) begin n_fail++; $display("[TB] FAIL edge_vpp: got %0d expected 3845", bus_a.vpp); end
    n_checks++; if (bus_a.sample_cnt !== 16'd6) begin n_fail++; $display("[TB] FAIL edge_cnt: got %0d expected 6", bus_a.sample_cnt); end
    n_checks++; if (done_b != 23) begin n_fail++; $display("[TB] FAIL edge1_done_cycle: got %0d expected 23", done_b); end
    n_checks++; if (b_vmax !== 12'd4095) begin n_fail++; $display("[TB] FAIL edge1_vmax: got %0d expected 4095", b_vmax); end
    n_checks++; if (b_vmin !== 12'd300) begin n_fail++; $display("[TB] FAIL edge1_vmin: got %0d expected 300", b_vmin); end
    n_checks++; if (b_cnt !== 16'd3) begin n_fail++; $display("[TB] FAIL edge1_cnt: got %0d expected 3", b_cnt); end
  endtask

  // One-period window on dut_b with no sample_en at all.
  task automatic test_no_samples();
    int done_b = -1;
    do_reset(1'b0);
    pulse_start();
    for (int t = 0; t < 150; t++) begin
      signal_in = sig_at(t, 4, 30);
      sample_en = 1'b0;
      step();
      if (bus_b.done === 1'b1) begin
        done_b = t;
        break;
      end
    end
    n_checks++; if (done_b != 34) begin n_fail++; $display("[TB] FAIL empty_done_cycle: got %0d expected 34", done_b); end
    n_checks++; if (bus_b.timeout !== 1'b0) begin n_fail++; $display("[TB] FAIL empty_timeout: got %b expected 0", bus_b.timeout); end
    n_checks++; if (bus_b.vmax !== 12'd0) begin n_fail++; $display("[TB] FAIL empty_vmax: got %0d expected 0", bus_b.vmax); end
    n_checks++; if (bus_b.vmin !== 12'd4095) begin n_fail++; $display("[TB] FAIL empty_vmin: got %0d expected 4095", bus_b.vmin); end
    n_checks++; if (bus_b.vpp !== 12'd0) begin n_fail++; $display("[TB] FAIL empty_vpp: got %0d expected 0", bus_b.vpp); end
    n_checks++; if (bus_b.sample_cnt !== 16'd0) begin n_fail++; $display("[TB] FAIL empty_cnt: got %0d expected 0", bus_b.sample_cnt); end
  endtask

  // A one-cycle reset in the middle of a dut_a measurement aborts it
  // silently; a fresh start afterwards measures normally.
  task automatic test_reset_mid_measure();
    int done_count = 0;
    int done_at    = -1;
    do_reset(1'b0);
    pulse_start();
    for (int t = 0; t < 20; t++) begin
      signal_in = sig_at(t, 2, 10);
      sample_en = (t == 4);
      adc_data  = 12'd3000;
      step();
    end
    sample_en = 1'b0;
    rst       = 1'b1;
    step();
    rst = 1'b0;
    n_checks++; if (bus_a.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_busy: got %b expected 0", bus_a.busy); end
    n_checks++; if (bus_a.done !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_done: got %b expected 0", bus_a.done); end
    for (int t = 0; t < 12; t++) begin
      signal_in = sig_at(t, 1, 6);
      step();
      if (bus_a.done === 1'b1) done_count++;
    end
    n_checks++; if (done_count != 0) begin n_fail++; $display("[TB] FAIL midrst_no_done: got %0d pulses expected 0", done_count); end
    signal_in = 1'b0;
    pulse_start();
    for (int t = 0; t < 150; t++) begin
      signal_in = sig_at(t, 2, 10);
      sample_en = (t == 4) || (t == 14) || (t == 17) || (t == 22);
      case (t)
        4:       adc_data = 12'd50;
        14:      adc_data = 12'd70;
        17:      adc_data = 12'd30;
        default: adc_data = 12'd4000;
      endcase
      step();
      if (bus_a.done === 1'b1) begin
        done_at = t;
        break;
      end
    end
    sample_en = 1'b0;
    n_checks++; if (done_at != 22) begin n_fail++; $display("[TB] FAIL midrst_redo_done_cycle: got %0d expected 22", done_at); end
    n_checks++; if (bus_a.vmax !== 12'd70) begin n_fail++; $display("[TB] FAIL midrst_redo_vmax: got %0d expected 70", bus_a.vmax); end
    n_checks++; if (bus_a.vmin !== 12'd30) begin n_fail++; $display("[TB] FAIL midrst_redo_vmin: got %0d expected 30", bus_a.vmin); end
    n_checks++; if (bus_a.vpp !== 12'd40) begin n_fail++; $display("[TB] FAIL midrst_redo_vpp: got %0d expected 40", bus_a.vpp); end
    n_checks++; if (bus_a.sample_cnt !== 16'd3) begin n_fail++; $display("[TB] FAIL midrst_redo_cnt: got %0d expected 3", bus_a.sample_cnt); end
  endtask

  // Extra starts in WAIT_EDGE (t=5) and MEASURE (t=30) are ignored. The
  // closing rise at t=98 coincides with the last cycle before the 100-cycle
  // abort, and completion must win.
  task automatic test_busy_start_and_tie();
    int done_at = -1;
    do_reset(1'b0);
    pulse_start();
    for (int t = 0; t < 150; t++) begin
      signal_in = sig_at(t, 18, 40);
      start     = (t == 5) || (t == 30);
      sample_en = (t == 28) || (t == 68) || (t == 88);
      case (t)
        28:      adc_data = 12'd500;
        68:      adc_data = 12'd1500;
        88:      adc_data = 12'd800;
        default: adc_data = 12'd0;
      endcase
      step();
      if (bus_a.done === 1'b1) begin
        done_at = t;
        break;
      end
    end
    start     = 1'b0;
    sample_en = 1'b0;
    n_checks++; if (done_at != 98) begin n_fail++; $display("[TB] FAIL tie_done_cycle: got %0d expected 98", done_at); end
    n_checks++; if (bus_a.timeout !== 1'b0) begin n_fail++; $display("[TB] FAIL tie_timeout: got %b expected 0", bus_a.timeout); end
    n_checks++; if (bus_a.vmax !== 12'd1500) begin n_fail++; $display("[TB] FAIL tie_vmax: got %0d expected 1500", bus_a.vmax); end
    n_checks++; if (bus_a.vmin !== 12'd500) begin n_fail++; $display("[TB] FAIL tie_vmin: got %0d expected 500", bus_a.vmin); end
    n_checks++; if (bus_a.vpp !== 12'd1000) begin n_fail++; $display("[TB] FAIL tie_vpp: got %0d expected 1000", bus_a.vpp); end
    n_checks++; if (bus_a.sample_cnt !== 16'd3) begin n_fail++; $display("[TB] FAIL tie_cnt: got %0d expected 3", bus_a.sample_cnt); end
  endtask

  // Entered in the done cycle left by the previous task: start is raised in
  // the very next cycle and must be accepted, then an empty 2-period window
  // completes normally.
  task automatic test_back_to_back();
    int done_at = -1;
    signal_in = 1'b0;
    step();
    n_checks++; if (bus_a.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_idle_busy: got %b expected 0", bus_a.busy); end
    pulse_start();
    n_checks++; if (bus_a.busy !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_busy: got %b expected 1", bus_a.busy); end
    for (int t = 0; t < 150; t++) begin
      signal_in = sig_at(t, 3, 20);
      step();
      if (bus_a.done === 1'b1) begin
        done_at = t;
        break;
      end
    end
    n_checks++; if (done_at != 43) begin n_fail++; $display("[TB] FAIL b2b_done_cycle: got %0d expected 43", done_at); end
    n_checks++; if (bus_a.timeout !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_timeout: got %b expected 0", bus_a.timeout); end
    n_checks++; if (bus_a.sample_cnt !== 16'd0) begin n_fail++; $display("[TB] FAIL b2b_cnt: got %0d expected 0", bus_a.sample_cnt); end
    n_checks++; if (bus_a.vmin !== 12'd4095) begin n_fail++; $display("[TB] FAIL b2b_vmin: got %0d expected 4095", bus_a.vmin); end
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    sample_en = 1'b0;
    signal_in = 1'b1;
    adc_data  = '0;
    $display("[TB] period_peak_tracker directed tests");
    test_reset();
    test_timeout_no_edge();
    test_ramp();
    test_edge_samples();
    test_no_samples();
    test_reset_mid_measure();
    test_busy_start_and_tie();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/period_peak_tracker.md
Name: period_peak_tracker

Overview:
- Measures the per-period extremes of the ADC stream, synchronised to the comparator square wave.
- Sits beside the gain/frequency loop. Consumes the synchronised ADC samples and the synchronised signal_in, and produces max, min and peak-to-peak values plus a sample count over NUM_PERIODS whole signal periods.
- Results feed the gain decision logic and the wave-information register bank.

Parameters:
- NUM_PERIODS, 4, number of signal_in rising-edge-to-rising-edge periods per measurement (1..255).
- TIMEOUT_CYC, 50_000_000, clk cycles allowed from start to done before aborting (>=2).
- DW, 12, ADC sample width.

Ports:
- clk  in  1  system clock, sole clock domain.
- rst  in  1  synchronous reset, active-high.
- sample_en  in  1  one-cycle strobe marking a valid adc_data sample.
- adc_data  in  DW  synchronised ADC sample, unsigned.
- signal_in  in  1  comparator square wave, already synchronised to clk.
- start  in  1  one-cycle request to begin a measurement.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when results are updated (normal or timeout).
- timeout  out  1  status of the last measurement: 1 = aborted.
- vmax  out  DW  maximum sample of the last measurement.
- vmin  out  DW  minimum sample of the last measurement.
- vpp  out  DW  vmax-vmin, or 0 if vmax<vmin.
- sample_cnt  out  16  samples taken in the last measurement, saturating at 65535.

Behaviour:
- Reset (rst high at a clk edge):
  - state=IDLE; busy=0, done=0, timeout=0, vmax=0, vmin=0, vpp=0, sample_cnt=0.
  - sig_d=1, so a signal_in that is high out of reset is not treated as an edge.
  - Period and timeout counters cleared.
- Reset mid-measurement aborts immediately with no done pulse.
- Edge detect: rise = signal_in & ~sig_d; sig_d registered every cycle.
- States:
  - IDLE:
    - start=1 -> WAIT_EDGE; clear timeout counter; busy=1 next cycle.
    - start is ignored in every other state.
  - WAIT_EDGE:
    - On rise -> MEASURE with period_cnt=0.
    - Working max/min/cnt are initialised on that cycle. If sample_en is also high: max=min=adc_data, cnt=1. Otherwise: max=0, min=2^DW-1, cnt=0.
  - MEASURE:
    - Each sample_en updates max, min and cnt (cnt saturates).
    - On rise: period_cnt++. If period_cnt reaches NUM_PERIODS -> DONE.
    - A sample coincident with the terminating rise is excluded; it belongs to the next period.
  - DONE (one cycle):
    - Copy max/min/cnt into vmax/vmin/sample_cnt.
    - vpp = (max>=min) ? max-min : 0.
    - timeout=0, done=1, busy=0; -> IDLE.
  - Timeout counter increments every cycle in WAIT_EDGE and MEASURE. When it reaches TIMEOUT_CYC-1 with no completion -> ABORT.
  - ABORT (one cycle): timeout=1, done=1, busy=0. vmax, vmin, vpp and sample_cnt keep their previous values. -> IDLE.
- If the final rise and timeout expiry occur in the same cycle, normal completion wins (DONE).
- Zero samples in a window: vmax=0, vmin=2^DW-1, vpp=0, sample_cnt=0.
- Latency:
  - done asserts 1 cycle after the terminating rise.
  - start-to-busy is 1 cycle.
  - Back-to-back start is accepted on the cycle after done.
- All outputs are registered; results are stable between done pulses.

Test Plan:
- Reset with signal_in held high, then start with no toggling and TIMEOUT_CYC=100 -> no measurement starts; done pulses with timeout=1 exactly 100 cycles after start; vmax/vmin/vpp/sample_cnt stay 0.
- Case NUM_PERIODS=2, period 40 clk, sample_en every 4 clk, ramp 100..1000 with wrap -> done 1 cycle after the 3rd rise after start; sample_cnt=20; vmax=1000, vmin=100, vpp=900.
- Sample_en coincident with rises, values 4095 at the start edge and 0 at the end edge -> vmax=4095 (included); value 0 excluded, so vmin equals the smallest in-window sample.
- No sample_en during a NUM_PERIODS=1 window -> vpp=0, vmin=4095, vmax=0, sample_cnt=0, timeout=0.
- Rst asserted mid-MEASURE for 1 cycle -> busy=0 next cycle, no done; a later start completes normally.
- Start pulsed while busy, and final rise coincident with timeout expiry -> the extra start is ignored; done with timeout=0 and valid results.
